// File: rtl/iomem_arbiter.sv
// iomem_arbiter: shares one iomem slave bus between two iomem masters.
//
// Master 0 is the soc iomem port, master 1 a secondary master (debug/DMA).
// A request is captured into registers in IDLE and presented on s_* during
// BUSY. Ties are broken round-robin. A granted access that waits too long
// for s_ready is aborted and the master gets TIMEOUT_RDATA.
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   m0_* / m1_*                  master request (valid/wstrb/addr/wdata) and
//                                completion (ready pulse, rdata)
//   s_valid/s_wstrb/s_addr/s_wdata   captured request to the slave
//   s_ready/s_rdata              slave completion and read data
//   timeout_pulse                one-cycle pulse on an aborted access
//   timeout_flag                 sticky abort indicator, cleared by timeout_clr
//   timeout_master               master id of the most recent abort
//   timeout_clr                  clears timeout_flag on the next edge
module iomem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        resetn,

   input  logic        m0_valid,
   output logic        m0_ready,
   input  logic [3:0]  m0_wstrb,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic [31:0] m0_rdata,

   input  logic        m1_valid,
   output logic        m1_ready,
   input  logic [3:0]  m1_wstrb,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic [31:0] m1_rdata,

   output logic        s_valid,
   input  logic        s_ready,
   output logic [3:0]  s_wstrb,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   input  logic [31:0] s_rdata,

   output logic        timeout_pulse,
   output logic        timeout_flag,
   output logic        timeout_master,
   input  logic        timeout_clr
);

   typedef enum logic {StIdle, StBusy} state_e;

   state_e      state_q, state_d;
   logic        grant_q, grant_d;
   logic        last_grant_q, last_grant_d;
   logic [31:0] counter_q, counter_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        flag_q, flag_d;
   logic        tmaster_q, tmaster_d;

   logic        sel;
   logic        done;
   logic        abort;
   logic        finish;
   logic [31:0] resp_data;

   // Tie goes to the master that did not win last time; otherwise the sole requester.
   always_comb begin
      sel = m1_valid;
      if (m0_valid && m1_valid) begin
         sel = ~last_grant_q;
      end
   end

   // s_ready in the last allowed cycle wins over the abort.
   always_comb begin
      done   = (state_q == StBusy) && s_ready;
      abort  = (state_q == StBusy) && !s_ready && (TIMEOUT_CYCLES != 0) &&
               (counter_q == TIMEOUT_CYCLES - 1);
      finish = done || abort;
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      counter_d    = counter_q;
      wstrb_d      = wstrb_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      flag_d       = flag_q;
      tmaster_d    = tmaster_q;

      if (timeout_clr) begin
         flag_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (m0_valid || m1_valid) begin
               grant_d      = sel;
               last_grant_d = sel;
               counter_d    = '0;
               wstrb_d      = sel ? m1_wstrb : m0_wstrb;
               addr_d       = sel ? m1_addr  : m0_addr;
               wdata_d      = sel ? m1_wdata : m0_wdata;
               state_d      = StBusy;
            end
         end
         StBusy: begin
            // Granted master dropping valid here is ignored; the access runs to the end.
            if (finish) begin
               state_d = StIdle;
            end else begin
               counter_d = counter_q + 32'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      // A new abort overrides a simultaneous clear.
      if (abort) begin
         flag_d    = 1'b1;
         tmaster_d = grant_q;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= StIdle;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         counter_q    <= '0;
         wstrb_q      <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         flag_q       <= 1'b0;
         tmaster_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         counter_q    <= counter_d;
         wstrb_q      <= wstrb_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         flag_q       <= flag_d;
         tmaster_q    <= tmaster_d;
      end
   end

   always_comb begin
      resp_data      = abort ? TIMEOUT_RDATA : s_rdata;
      m0_ready       = finish && !grant_q;
      m1_ready       = finish && grant_q;
      m0_rdata       = m0_ready ? resp_data : 32'd0;
      m1_rdata       = m1_ready ? resp_data : 32'd0;
      s_valid        = (state_q == StBusy);
      s_wstrb        = wstrb_q;
      s_addr         = addr_q;
      s_wdata        = wdata_q;
      timeout_pulse  = abort;
      timeout_flag   = flag_q;
      timeout_master = tmaster_q;
   end

endmodule
